// File: rtl/my_screen_scanner_if.sv
// Screen read port plus pixel stream of the screen scanner.
// The master side is the scanner; the slave side is the screen memory / pixel sink.
interface my_screen_scanner_if;
    logic [12:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        pix;
    logic        pix_valid;
    logic        pix_ready;
    logic        sof;
    logic        eol;
    logic        eof;

    modport master (
        output rd_addr, rd_en, pix, pix_valid, sof, eol, eof,
        input  rd_data, pix_ready
    );

    modport slave (
        input  rd_addr, rd_en, pix, pix_valid, sof, eol, eof,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/my_screen_scanner.sv
// Raster scanner: reads 16-pixel screen words row-major and streams them out one pixel
// per transfer with frame/line markers. FRAME_WORDS sets the frame size (8192 = 256x512).
module my_screen_scanner #(
    parameter int FRAME_WORDS = 8192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    my_screen_scanner_if.master  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    localparam logic [12:0] LAST_WORD = 13'(FRAME_WORDS - 1);

    state_t      state_q,     state_d;
    logic [12:0] word_ptr_q,  word_ptr_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] shift_q,     shift_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        rd_en_q,     rd_en_d;
    logic        pix_q,       pix_d;
    logic        pix_valid_q, pix_valid_d;
    logic        sof_q,       sof_d;
    logic        eol_q,       eol_d;
    logic        eof_q,       eof_d;
    logic        busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        word_ptr_d  = word_ptr_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    word_ptr_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                shift_d   = bus.rd_data;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bus.pix_ready) begin
                    shift_d   = {1'b0, shift_q[15:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        if (word_ptr_q != LAST_WORD) begin
                            word_ptr_d = word_ptr_q + 13'd1;
                            state_d    = LOAD;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            // enable is only looked at here, so a frame always completes
                            if (enable) begin
                                word_ptr_d = '0;
                                state_d    = LOAD;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the block registered
        rd_en_d     = (state_d == LOAD);
        pix_valid_d = (state_d == SHIFT);
        pix_d       = pix_valid_d & shift_d[0];
        sof_d       = pix_valid_d && (word_ptr_d == 13'd0) && (bit_cnt_d == 4'd0);
        eol_d       = pix_valid_d && (word_ptr_d[4:0] == 5'd31) && (bit_cnt_d == 4'd15);
        eof_d       = pix_valid_d && (word_ptr_d == LAST_WORD) && (bit_cnt_d == 4'd15);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            word_ptr_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            pix_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_ptr_q  <= word_ptr_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
            rd_en_q     <= rd_en_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rd_addr   = word_ptr_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.pix       = pix_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.sof       = sof_q;
    assign bus.eol       = eol_q;
    assign bus.eof       = eof_q;
    assign busy          = busy_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/my_screen_scanner.md
MY_SCREEN_SCANNER -- requirements
Module: my_screen_scanner

Interface
REQ-001 The block SHALL use exactly one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: reset  input  1  asynchronous active-high reset; clears all state immediately.
REQ-004 Port: enable  input  1  when high, the block scans frames continuously; sampled only at frame boundaries and in IDLE.
REQ-005 Port: rd_addr  output  13  screen word address (row*32 + col/16) presented to the screen read port.
REQ-006 Port: rd_en  output  1  high for one cycle while rd_addr is valid and rd_data is captured.
REQ-007 Port: rd_data  input  16  screen word; combinationally valid for the rd_addr presented in the same cycle.
REQ-008 Port: pix  output  1  current pixel (1 = black).
REQ-009 Port: pix_valid  output  1  pix and the sof/eol/eof flags are valid.
REQ-010 Port: pix_ready  input  1  downstream accepts the pixel; a transfer occurs on a cycle with pix_valid and pix_ready both high.
REQ-011 Port: sof  output  1  qualifies pixel (0,0) of a frame.
REQ-012 Port: eol  output  1  qualifies the last pixel of a row (column 511).
REQ-013 Port: eof  output  1  qualifies pixel (255,511), the last of the frame.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: frame_cnt  output  8  completed-frame counter; wraps from 255 to 0.

Function
REQ-016 The geometry SHALL be 256 rows x 512 columns, stored as 32 words per row and 8192 words in total.
REQ-017 Pixel order SHALL be row-major; within a word, bit 0 is the leftmost pixel and bit 15 is the rightmost.
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD and SHIFT.
REQ-019 IDLE: pix_valid=0, rd_en=0; if enable=1, word_ptr is set to 0 and the FSM goes to LOAD on the next edge.
REQ-020 LOAD: rd_addr=word_ptr, rd_en=1, pix_valid=0; rd_data is captured into a 16-bit shift register, bit_cnt is cleared, and the FSM goes to SHIFT; LOAD lasts exactly 1 cycle.
REQ-021 SHIFT: pix_valid=1 and pix=shift[0]; on each transfer the register shifts right by 1 and bit_cnt increments; without a transfer, pix and all flags SHALL hold stable.
REQ-022 On the transfer with bit_cnt=15, the next state SHALL be chosen as follows:
- word_ptr != 8191: word_ptr+1 and go to LOAD.
- word_ptr = 8191: frame_cnt increments; if enable=1, word_ptr returns to 0 and the FSM goes to LOAD; otherwise the FSM goes to IDLE.
REQ-023 sof SHALL be high only when word_ptr=0 and bit_cnt=0; eol only when word_ptr[4:0]=31 and bit_cnt=15; eof only when word_ptr=8191 and bit_cnt=15.
REQ-024 Throughput SHALL be 16 pixels per 17 cycles with pix_ready held high: one bubble cycle (LOAD) per word.
REQ-025 Latency SHALL be 2 cycles from enable sampled high in IDLE to the first pix_valid.
REQ-026 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes and the FSM then goes to IDLE.
REQ-027 rd_addr SHALL equal word_ptr in every state; rd_en SHALL be high only in LOAD.
REQ-028 Screen contents changed after a word's LOAD SHALL NOT affect that word's pixels already captured in the shift register.

Reset
REQ-029 Reset SHALL force the state to IDLE, word_ptr=0, bit_cnt=0, shift=0 and frame_cnt=0.
REQ-030 While reset is high, pix_valid, pix, rd_en, sof, eol, eof and busy SHALL all be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no eof and no frame_cnt increment.
REQ-032 After reset deasserts, scanning SHALL restart from word 0 when enable is high.

Verification
REQ-033 Bit order: word 0 = 16'h0001, all other words 0, pix_ready=1, enable=1 -> first transferred pixel pix=1 with sof=1; the next 15 pixels are 0; LOAD issues rd_addr=1 on cycle 18.
REQ-034 Frame count: full frame with pix_ready=1 and enable dropped after start -> exactly 131072 transfers, 8192 rd_en pulses, 256 eol pulses, one eof on the last transfer, frame_cnt=1, then IDLE with busy=0.
REQ-035 Backpressure: pix_ready toggles 1,0,0,1 repeatedly -> pix and flags stay stable during stalls; the pixel sequence matches the no-stall run bit-for-bit.
REQ-036 Continuous mode: enable held high for 2 frames -> LOAD with rd_addr=0 directly follows eof (no IDLE cycle); frame_cnt=2; the second sof occurs 2 cycles after the eof transfer.
REQ-037 Reset mid-frame: reset pulsed at word_ptr=100, bit_cnt=7 -> outputs go to 0 immediately, frame_cnt stays 0, and the restart begins at rd_addr=0 with sof=1.
REQ-038 Wrap: run 256 frames -> frame_cnt returns to 0 after the 256th eof.
